alu_logic_scheduler: RTL and testbench

Sequencer and round-robin arbiter that shares the 8-bit logic-unit datapath (AND/OR/XOR units feeding the 4-to-1 logic select mux) between several requesters. It accepts one operation at a time over a valid/ready handshake and drives operands and the 2-bit mux select. It captures the mux output and returns the result with the requester ID over a response handshake. It sits between the instruction/requester front-ends and the ALU logic slice.

---
 rtl/alu_logic_scheduler.sv | 158 +++++++++++++++
 tb/tb_alu_logic_scheduler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_logic_scheduler.sv
// rtl/alu_logic_scheduler.sv - round-robin sequencer sharing the AND/OR/XOR logic slice
module alu_logic_scheduler #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [2*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    output logic [1:0]            mux_select,
    output logic [WIDTH-1:0]      lu_a,
    output logic [WIDTH-1:0]      lu_b,
    input  logic [WIDTH-1:0]      lu_result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [1:0]            rsp_id,
    output logic                  rsp_err
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic [1:0]       last_grant_q, last_grant_d;
    logic [1:0]       mux_select_q, mux_select_d;
    logic [WIDTH-1:0] lu_a_q, lu_a_d;
    logic [WIDTH-1:0] lu_b_q, lu_b_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]       rsp_id_q, rsp_id_d;
    logic             rsp_err_q, rsp_err_d;

    logic             found;
    logic [1:0]       grant;
    logic [2:0]       cand;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    // Search upward from the requester after the last winner, wrapping at NREQ.
    always_comb begin
        found = 1'b0;
        grant = 2'd0;
        cand  = 3'd0;
        for (int k = 0; k < NREQ; k++) begin
            cand = 3'(last_grant_q) + 3'd1 + 3'(k);
            if (cand >= 3'(NREQ)) begin
                cand = cand - 3'(NREQ);
            end
            if (!found && req_valid[cand[1:0]]) begin
                found = 1'b1;
                grant = cand[1:0];
            end
        end
    end

    always_comb begin
        sel_op = 2'd0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant == 2'(i)) begin
                sel_op = req_op[2*i +: 2];
                sel_a  = req_a[WIDTH*i +: WIDTH];
                sel_b  = req_b[WIDTH*i +: WIDTH];
            end
        end
    end

    // Gated by rst_n so no accept is advertised while reset is held.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = rst_n && (state_q == IDLE) && found && (grant == 2'(i));
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mux_select_d = mux_select_q;
        lu_a_d       = lu_a_q;
        lu_b_d       = lu_b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    last_grant_d = grant;
                    rsp_id_d     = grant;
                    if (sel_op == 2'd3) begin
                        // Illegal op answers directly; the mux never sees select 3.
                        rsp_data_d  = '0;
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end else begin
                        mux_select_d = sel_op;
                        lu_a_d       = sel_a;
                        lu_b_d       = sel_b;
                        state_d      = EXEC;
                    end
                end
            end
            EXEC: begin
                rsp_data_d  = lu_result;
                rsp_err_d   = 1'b0;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 2'(NREQ - 1);
            mux_select_q <= 2'd0;
            lu_a_q       <= '0;
            lu_b_q       <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= 2'd0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mux_select_q <= mux_select_d;
            lu_a_q       <= lu_a_d;
            lu_b_q       <= lu_b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign mux_select = mux_select_q;
    assign lu_a       = lu_a_q;
    assign lu_b       = lu_b_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_logic_scheduler.sv
// tb/tb_alu_logic_scheduler.sv - bench for alu_logic_scheduler
module tb_alu_logic_scheduler;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [5:0]  req_op;
    logic [23:0] req_a;
    logic [23:0] req_b;
    logic [1:0]  mux_select;
    logic [7:0]  lu_a;
    logic [7:0]  lu_b;
    logic [7:0]  lu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_id;
    logic        rsp_err;

    int checks;
    int errors;
    logic sel3_seen;

    alu_logic_scheduler #(.WIDTH(8), .NREQ(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .mux_select (mux_select),
        .lu_a       (lu_a),
        .lu_b       (lu_b),
        .lu_result  (lu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Logic slice: AND/OR/XOR units behind the 4-to-1 mux; in3 is a visible sentinel.
    always_comb begin
        case (mux_select)
            2'd0:    lu_result = lu_a & lu_b;
            2'd1:    lu_result = lu_a | lu_b;
            2'd2:    lu_result = lu_a ^ lu_b;
            default: lu_result = 8'hEE;
        endcase
    end

    initial sel3_seen = 1'b0;
    always @(negedge clk) begin
        if (mux_select == 2'd3) sel3_seen = 1'b1;
    end

    typedef struct {
        logic [1:0] rid;
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_payload(input logic [1:0] rid, input logic [1:0] op,
                               input logic [7:0] a, input logic [7:0] b);
        req_op[2*rid +: 2] = op;
        req_a[8*rid +: 8]  = a;
        req_b[8*rid +: 8]  = b;
    endtask

    task automatic run_single(input vec_t v);
        logic [2:0] onehot;
        onehot = 3'b001 << v.rid;
        @(negedge clk);
        set_payload(v.rid, v.op, v.a, v.b);
        req_valid = onehot;
        #1;
        check("single_ready", 32'(req_ready), 32'(onehot));
        @(negedge clk);
        req_valid = 3'b000;
        #1;
        if (v.op != 2'd3) begin
            check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
            check("exec_mux_select", 32'(mux_select), 32'(v.op));
            check("exec_lu_a", 32'(lu_a), 32'(v.a));
            check("exec_lu_b", 32'(lu_b), 32'(v.b));
            @(negedge clk);
            #1;
        end
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_data", 32'(rsp_data), 32'(v.exp_data));
        check("rsp_id", 32'(rsp_id), 32'(v.rid));
        check("rsp_err", 32'(rsp_err), 32'(v.exp_err));
        check("rsp_ready_blocked", 32'(req_ready), 32'd0);
        @(negedge clk);
        #1;
        check("rsp_drop", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [7:0] rr_exp [3];
        int t;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 3'b111;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;

        tbl[0] = '{2'd0, 2'd0, 8'hF0, 8'h3C, 8'h30, 1'b0};
        tbl[1] = '{2'd1, 2'd1, 8'hF0, 8'h0F, 8'hFF, 1'b0};
        tbl[2] = '{2'd2, 2'd2, 8'hAA, 8'hFF, 8'h55, 1'b0};
        tbl[3] = '{2'd1, 2'd3, 8'h12, 8'h34, 8'h00, 1'b1};
        tbl[4] = '{2'd2, 2'd0, 8'hFF, 8'h81, 8'h81, 1'b0};
        tbl[5] = '{2'd0, 2'd2, 8'h5A, 8'h5A, 8'h00, 1'b0};
        tbl[6] = '{2'd1, 2'd1, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[7] = '{2'd0, 2'd3, 8'hFF, 8'hFF, 8'h00, 1'b1};

        // Reset held with every requester valid.
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mux_select", 32'(mux_select), 32'd0);
        check("rst_lu_a", 32'(lu_a), 32'd0);
        check("rst_lu_b", 32'(lu_b), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_first_grant", 32'(req_ready), 32'b001);
        req_valid = 3'b000;

        for (int i = 0; i < 8; i++) begin
            run_single(tbl[i]);
        end

        // Round-robin with all three requesters valid continuously.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        set_payload(2'd0, 2'd1, 8'hF0, 8'h0F);
        set_payload(2'd1, 2'd2, 8'hAA, 8'hFF);
        set_payload(2'd2, 2'd0, 8'hFF, 8'h81);
        rr_exp[0] = 8'hFF;
        rr_exp[1] = 8'h55;
        rr_exp[2] = 8'h81;
        req_valid = 3'b111;
        #1;
        for (int n = 0; n < 6; n++) begin
            t = 0;
            while (req_ready == 3'b000 && t < 10) begin
                @(negedge clk);
                #1;
                t++;
            end
            check("rr_grant", 32'(req_ready), 32'(3'b001 << (n % 3)));
            @(negedge clk);
            #1;
            t = 0;
            while (!rsp_valid && t < 10) begin
                @(negedge clk);
                #1;
                t++;
            end
            check("rr_rsp_valid", 32'(rsp_valid), 32'd1);
            check("rr_rsp_data", 32'(rsp_data), 32'(rr_exp[n % 3]));
            check("rr_rsp_id", 32'(rsp_id), 32'(n % 3));
            @(negedge clk);
            #1;
        end
        req_valid = 3'b000;

        // Backpressure with req2 pending behind req0.
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 3'b101;
        #1;
        check("bp_grant0", 32'(req_ready), 32'b001);
        @(negedge clk);
        req_valid = 3'b100;
        #1;
        check("bp_exec_ready", 32'(req_ready), 32'd0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_data", 32'(rsp_data), 32'hFF);
            check("bp_rsp_id", 32'(rsp_id), 32'd0);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bp_released", 32'(rsp_valid), 32'd0);
        check("bp_grant2", 32'(req_ready), 32'b100);
        @(negedge clk);
        req_valid = 3'b000;
        #1;
        check("bp_exec_sel", 32'(mux_select), 32'd0);
        check("bp_exec_a", 32'(lu_a), 32'hFF);
        @(negedge clk);
        #1;
        check("bp_rsp2_data", 32'(rsp_data), 32'h81);
        check("bp_rsp2_id", 32'(rsp_id), 32'd2);

        // Reset during EXEC aborts the op.
        @(negedge clk);
        req_valid = 3'b001;
        #1;
        check("mid_grant0", 32'(req_ready), 32'b001);
        @(negedge clk);
        req_valid = 3'b000;
        #1;
        check("mid_exec_sel", 32'(mux_select), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_sel", 32'(mux_select), 32'd0);
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            check("mid_no_rsp", 32'(rsp_valid), 32'd0);
        end
        req_valid = 3'b111;
        #1;
        check("mid_first_grant", 32'(req_ready), 32'b001);
        req_valid = 3'b000;
        @(negedge clk);
        #1;
        check("never_sel3", 32'(sel3_seen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
